// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush sequencer.
// Stall bit indices, exception_type bit positions and the default exception entry.
package pipeline_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
  localparam int STALL_W   = 6;

  localparam int EXC_ERET         = 7;
  localparam int EXC_ADE          = 6;
  localparam int EXC_SYSCALL      = 5;
  localparam int EXC_BREAK        = 4;
  localparam int EXC_TP           = 3;
  localparam int EXC_OVERFLOW     = 2;
  localparam int EXC_INVALID_INST = 1;
  localparam int EXC_IF           = 0;
  localparam int EXC_TYPE_BUS     = 8;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC00380;

  typedef enum logic {
    RUN,
    REDIRECT
  } ctrl_state_t;

  // eret returns to EPC and outranks every other cause bit
  function automatic logic [31:0] exc_target(input logic [EXC_TYPE_BUS-1:0] exc_type,
                                             input logic [31:0] epc,
                                             input logic [31:0] vector);
    return exc_type[EXC_ERET] ? epc : vector;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_encoder.sv
// Priority encoder turning per-stage stall requests into the 6-bit hold vector.
// A stalled stage also holds every stage upstream of it; flush clears everything.
module stall_encoder
  import pipeline_ctrl_pkg::*;
(
  input  logic               flush,
  input  logic               req_if,
  input  logic               req_id,
  input  logic               req_ex,
  input  logic               req_mem,
  output logic [STALL_W-1:0] stall
);

  always_comb begin
    stall = '0;
    if (flush)
      stall = 6'b000000;
    else if (req_mem)
      stall = 6'b011111;
    else if (req_ex)
      stall = 6'b001111;
    else if (req_id)
      stall = 6'b000111;
    else if (req_if)
      stall = 6'b000011;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: merges stage stall requests, turns MEM exceptions
// into a one-cycle flush plus a held PC redirect, and counts stall/flush cycles.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
  parameter int          CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_request_if,
  input  logic                    stall_request_id,
  input  logic                    stall_request_ex,
  input  logic                    stall_request_mem,
  input  logic                    branch_is_error,
  input  logic [EXC_TYPE_BUS-1:0] exception_type,
  input  logic [31:0]             cp0_epc,
  output logic [STALL_W-1:0]      stall,
  output logic                    flush,
  output logic                    if_kill,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  ctrl_state_t        state;
  ctrl_state_t        next_state;
  logic               exc_take;
  logic [STALL_W-1:0] enc_stall;
  logic [STALL_W-1:0] fetch_hold;
  logic [CNT_W-1:0]   cnt_one;

  // An exception waits in MEM until its data access completes
  assign exc_take = (|exception_type) & ~stall_request_mem;
  assign cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    fetch_hold = '0;
    fetch_hold[STALL_PC] = 1'b1;
    fetch_hold[STALL_IF] = 1'b1;
  end

  stall_encoder u_stall_encoder (
    .flush   (flush),
    .req_if  (stall_request_if),
    .req_id  (stall_request_id),
    .req_ex  (stall_request_ex),
    .req_mem (stall_request_mem),
    .stall   (enc_stall)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:      if (exc_take) next_state = REDIRECT;
      REDIRECT: if (!exc_take && !stall_request_if) next_state = RUN;
      default:  next_state = RUN;
    endcase
  end

  // Fetch is held while a redirect is pending so the PC can load the new target
  always_comb begin
    flush          = exc_take;
    if_kill        = branch_is_error & ~stall_request_id & ~exc_take & (state == RUN);
    redirect_valid = (state == REDIRECT);
    stall          = enc_stall;
    if (state == REDIRECT && !exc_take)
      stall = enc_stall | fetch_hold;
  end

  always_ff @(posedge clk) begin
    if (rst)
      redirect_pc <= '0;
    else if (exc_take)
      redirect_pc <= exc_target(exception_type, cp0_epc, EXC_VECTOR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall != '0)
        stall_cnt <= stall_cnt + cnt_one;
      if (flush)
        flush_cnt <= flush_cnt + cnt_one;
    end
  end

endmodule
